// File: rtl/ahb_slave_pkg.sv
// Shared types and constants for the AHB register slave: FSM states, AHB
// encodings, default register map and the sized write-merge helper.
package ahb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ERR,
    SEL_PAYLOAD,
    SEL_EXT,
    SEL_DSIZE
  } reg_sel_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int unsigned DEF_ERR_STATUS_ADDR = 1;
  localparam int unsigned DEF_PAYLOAD_ADDR    = 2;
  localparam int unsigned DEF_DATA_SIZE_ADDR  = 4;

  // Byte lanes outside the transfer size keep their old value.
  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  size);
    logic [31:0] r;
    r       = old_val;
    r[7:0]  = wdata[7:0];
    if (size != HSIZE_BYTE) r[15:8]  = wdata[15:8];
    if (size == HSIZE_WORD) r[31:16] = wdata[31:16];
    return r;
  endfunction

endpackage

// File: rtl/ahb_reg_slave_ctrl_if.sv
// AHB-lite slave bus bundle for the register slave.
// Handshake: an address phase is taken on a rising edge when hsel_x, hreadyin,
// hreadyout and htrans[1] are all high; its data phase ends on the first edge
// with hreadyout high, where hresp/hrdata are valid and hwdata is consumed.
interface ahb_reg_slave_ctrl_if;
  logic        hsel_x;
  logic        hwrite;
  logic        hreadyin;
  logic [2:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport master (
    output hsel_x, hwrite, hreadyin, haddr, htrans, hsize, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel_x, hwrite, hreadyin, haddr, htrans, hsize, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_reg_slave_ctrl_addr_map.sv
// Combinational address/size decode: selects the target register and flags
// illegal accesses (unmapped, oversized, or writes to the status register).
module AHB_address_mapping
  import ahb_slave_pkg::*;
#(
  parameter int unsigned ERR_STATUS_ADDRESS = DEF_ERR_STATUS_ADDR,
  parameter int unsigned PAYLOAD_ADDRESS    = DEF_PAYLOAD_ADDR,
  parameter int unsigned DATA_SIZE_ADDRESS  = DEF_DATA_SIZE_ADDR
) (
  input  logic [2:0] haddr,
  input  logic       hwrite,
  input  logic [2:0] hsize,
  output reg_sel_t   sel,
  output logic       err
);

  always_comb begin
    sel = SEL_NONE;
    err = 1'b0;
    if (haddr == 3'(ERR_STATUS_ADDRESS)) begin
      sel = SEL_ERR;
      err = hwrite || (hsize > HSIZE_HALF);
    end else if (haddr == 3'(PAYLOAD_ADDRESS)) begin
      sel = SEL_PAYLOAD;
      err = (hsize > HSIZE_WORD);
    end else if (haddr == 3'(PAYLOAD_ADDRESS + 1)) begin
      sel = SEL_EXT;
      err = (hsize > HSIZE_HALF);
    end else if (haddr == 3'(DATA_SIZE_ADDRESS)) begin
      sel = SEL_DSIZE;
      err = (hsize > HSIZE_HALF);
    end else begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_reg_slave_ctrl.sv
// AHB-lite register slave: payload, payload-extension and data-size registers,
// an error counter, optional OKAY wait states and two-cycle ERROR responses.
module ahb_reg_slave_ctrl
  import ahb_slave_pkg::*;
#(
  parameter int unsigned ERR_STATUS_ADDRESS = DEF_ERR_STATUS_ADDR,
  parameter int unsigned PAYLOAD_ADDRESS    = DEF_PAYLOAD_ADDR,
  parameter int unsigned DATA_SIZE_ADDRESS  = DEF_DATA_SIZE_ADDR,
  parameter int unsigned WAIT_STATES        = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_reg_slave_ctrl_if.slave   bus,
  output logic [31:0]           payload_q,
  output logic [15:0]           payload_ext_q,
  output logic [15:0]           data_size_q,
  output logic [15:0]           err_count,
  output state_t                dbg_state
);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  reg_sel_t   dec_sel;
  logic       dec_err;
  logic       active, accept, complete_ok;

  // Only OKAY transfers occupy the data-phase slot; errors are tracked by the FSM.
  logic       dp_valid;
  reg_sel_t   dp_sel;
  logic       dp_write;
  logic [2:0] dp_size;

  AHB_address_mapping #(
    .ERR_STATUS_ADDRESS (ERR_STATUS_ADDRESS),
    .PAYLOAD_ADDRESS    (PAYLOAD_ADDRESS),
    .DATA_SIZE_ADDRESS  (DATA_SIZE_ADDRESS)
  ) u_map (
    .haddr  (bus.haddr),
    .hwrite (bus.hwrite),
    .hsize  (bus.hsize),
    .sel    (dec_sel),
    .err    (dec_err)
  );

  assign active      = !(bus.htrans == HTRANS_IDLE || bus.htrans == HTRANS_BUSY);
  assign accept      = bus.hsel_x && bus.hreadyin && active && bus.hreadyout;
  assign complete_ok = (state == ST_IDLE) && dp_valid;
  assign dbg_state   = state;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (dec_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 2'(WAIT_STATES);
          end
        end
      end
      // The completing cycle of a waited transfer is spent back in IDLE.
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 2'd1;
        if (wait_cnt == 2'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = 32'h0;
    case (state)
      ST_WAIT: bus.hreadyout = 1'b0;
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
      end
      ST_ERR2: bus.hresp = 1'b1;
      default: ;
    endcase
    if (dp_valid && !dp_write && (state == ST_IDLE || state == ST_WAIT)) begin
      case (dp_sel)
        SEL_ERR:     bus.hrdata = {16'h0, err_count};
        SEL_PAYLOAD: bus.hrdata = payload_q;
        SEL_EXT:     bus.hrdata = {16'h0, payload_ext_q};
        SEL_DSIZE:   bus.hrdata = {16'h0, data_size_q};
        default:     bus.hrdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_sel   <= SEL_NONE;
      dp_write <= 1'b0;
      dp_size  <= 3'd0;
    end else if (bus.hreadyout) begin
      dp_valid <= accept && !dec_err;
      if (accept) begin
        dp_sel   <= dec_sel;
        dp_write <= bus.hwrite;
        dp_size  <= bus.hsize;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      payload_q     <= 32'h0;
      payload_ext_q <= 16'h0;
      data_size_q   <= 16'h0;
    end else if (complete_ok && dp_write) begin
      case (dp_sel)
        SEL_PAYLOAD: payload_q     <= merge_write(payload_q, bus.hwdata, dp_size);
        SEL_EXT:     payload_ext_q <= 16'(merge_write({16'h0, payload_ext_q}, bus.hwdata, dp_size));
        SEL_DSIZE:   data_size_q   <= 16'(merge_write({16'h0, data_size_q}, bus.hwdata, dp_size));
        default: ;
      endcase
    end
  end

  // Counts on ERR1 entry, which is exactly an accepted erroring address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_count <= 16'h0;
    end else if (accept && dec_err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ahb_reg_slave_ctrl.sv
// Bench for ahb_reg_slave_ctrl: two instances (0 and 2 wait states) behind a
// pipelined master, a reference register model and an expected-response queue.
module tb_ahb_reg_slave_ctrl;
  import ahb_slave_pkg::*;

  localparam int W = 38;  // {waits[3:0], hresp, hresp_during_waits, hrdata[31:0]}

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_reg_slave_ctrl_if bus0 ();
  ahb_reg_slave_ctrl_if bus2 ();

  logic        cur;
  logic        m_hsel, m_hwrite;
  logic [2:0]  m_haddr, m_hsize;
  logic [1:0]  m_htrans;
  logic [31:0] m_hwdata;
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  logic [31:0] pq0, pq2;
  logic [15:0] pe0, pe2, ds0, ds2, ec0, ec2;
  state_t      st0, st2;
  logic [31:0] cur_pay;
  logic [15:0] cur_ext, cur_ds, cur_err;
  state_t      cur_st;

  assign bus0.hsel_x   = m_hsel & ~cur;
  assign bus2.hsel_x   = m_hsel & cur;
  assign bus0.hwrite   = m_hwrite;
  assign bus2.hwrite   = m_hwrite;
  assign bus0.haddr    = m_haddr;
  assign bus2.haddr    = m_haddr;
  assign bus0.hsize    = m_hsize;
  assign bus2.hsize    = m_hsize;
  assign bus0.htrans   = m_htrans;
  assign bus2.htrans   = m_htrans;
  assign bus0.hwdata   = m_hwdata;
  assign bus2.hwdata   = m_hwdata;
  assign bus0.hreadyin = cur_ready;
  assign bus2.hreadyin = cur_ready;

  assign cur_ready = cur ? bus2.hreadyout : bus0.hreadyout;
  assign cur_resp  = cur ? bus2.hresp     : bus0.hresp;
  assign cur_rdata = cur ? bus2.hrdata    : bus0.hrdata;
  assign cur_pay   = cur ? pq2 : pq0;
  assign cur_ext   = cur ? pe2 : pe0;
  assign cur_ds    = cur ? ds2 : ds0;
  assign cur_err   = cur ? ec2 : ec0;
  assign cur_st    = cur ? st2 : st0;

  ahb_reg_slave_ctrl #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus0),
    .payload_q(pq0), .payload_ext_q(pe0), .data_size_q(ds0), .err_count(ec0),
    .dbg_state(st0)
  );

  ahb_reg_slave_ctrl #(.WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus2),
    .payload_q(pq2), .payload_ext_q(pe2), .data_size_q(ds2), .err_count(ec2),
    .dbg_state(st2)
  );

  // Scoreboard and reference model
  logic [W-1:0] exp_q[$];
  xfer_t        xq[$];
  logic [31:0]  m_pay;
  logic [15:0]  m_ext, m_ds, m_err;
  int           ws;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pay = 32'h0; m_ext = 16'h0; m_ds = 16'h0; m_err = 16'h0;
    exp_q.delete();
    xq.delete();
  endtask

  task automatic model_access(input xfer_t x, output logic [W-1:0] e);
    logic        err;
    logic [31:0] mask, rd;
    err  = 1'b0;
    rd   = 32'h0;
    mask = (x.size == 3'd0) ? 32'h0000_00FF : (x.size == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case (x.addr)
      3'd1: begin
        err = x.wr || (x.size > 3'd1);
        rd  = {16'h0, m_err};
      end
      3'd2: begin
        err = (x.size > 3'd2);
        if (!err && x.wr) m_pay = (m_pay & ~mask) | (x.wdata & mask);
        rd = m_pay;
      end
      3'd3: begin
        err = (x.size > 3'd1);
        if (!err && x.wr) m_ext = 16'((({16'h0, m_ext}) & ~mask) | (x.wdata & mask));
        rd = {16'h0, m_ext};
      end
      3'd4: begin
        err = (x.size > 3'd1);
        if (!err && x.wr) m_ds = 16'((({16'h0, m_ds}) & ~mask) | (x.wdata & mask));
        rd = {16'h0, m_ds};
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      e = {4'd1, 1'b1, 1'b1, 32'h0};
    end else begin
      e = {4'(ws), 1'b0, 1'b0, (x.wr ? 32'h0 : rd)};
    end
  endtask

  task automatic bus_idle();
    m_hsel = 1'b0; m_htrans = HTRANS_IDLE; m_hwrite = 1'b0;
    m_haddr = 3'd0; m_hsize = 3'd0; m_hwdata = 32'h0;
  endtask

  task automatic add(input logic [1:0] trans, input logic wr, input logic [2:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    xq.push_back(x);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      xfer_t x;
      if ($urandom_range(0, 7) == 0) x.trans = HTRANS_BUSY;
      else x.trans = ($urandom_range(0, 1) != 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      x.wr    = 1'($urandom_range(0, 1));
      x.addr  = 3'($urandom_range(0, 7));
      x.size  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      x.wdata = $urandom();
      xq.push_back(x);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_payload"},  W'(cur_pay), W'(m_pay));
    check({tag, "_ext"},      W'(cur_ext), W'(m_ext));
    check({tag, "_dsize"},    W'(cur_ds),  W'(m_ds));
    check({tag, "_errcount"}, W'(cur_err), W'(m_err));
  endtask

  // Pipelined master: entered and left at posedge+1, samples on the falling edge.
  task automatic run_queue(input string tag);
    xfer_t        cx;
    logic         have_addr, dp_act, rdy, resp_or;
    logic [31:0]  dp_wdata;
    logic [W-1:0] e;
    int           waits, guard, idx;
    have_addr = 1'b0; dp_act = 1'b0; rdy = 1'b1; resp_or = 1'b0;
    dp_wdata = 32'h0; waits = 0; guard = 0; idx = 0; cx = '0;
    while ((xq.size() > 0 || have_addr || dp_act) && guard < 4000) begin
      guard++;
      if (rdy) begin
        dp_act = have_addr && cx.trans[1];
        if (dp_act) begin
          dp_wdata = cx.wdata; waits = 0; resp_or = 1'b0;
        end
        have_addr = 1'b0;
        if (xq.size() > 0) begin
          cx = xq.pop_front();
          have_addr = 1'b1;
          m_hsel = 1'b1; m_htrans = cx.trans; m_hwrite = cx.wr;
          m_haddr = cx.addr; m_hsize = cx.size;
          if (cx.trans[1]) begin
            model_access(cx, e);
            exp_q.push_back(e);
          end
        end else begin
          m_hsel = 1'b0; m_htrans = HTRANS_IDLE;
        end
      end
      m_hwdata = dp_act ? dp_wdata : 32'h0;
      @(negedge hclk);
      rdy = cur_ready;
      if (dp_act) begin
        if (cur_ready) begin
          check($sformatf("%s_xfer%0d", tag, idx), {4'(waits), cur_resp, resp_or, cur_rdata},
                exp_q.pop_front());
          idx++;
          dp_act = 1'b0;
        end else begin
          waits++;
          resp_or = resp_or | cur_resp;
        end
      end else begin
        check({tag, "_idle_ready"}, W'(cur_ready), W'(1));
      end
      @(posedge hclk); #1;
    end
    if (guard >= 4000) check({tag, "_timeout"}, W'(guard), W'(0));
    bus_idle();
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    bus_idle();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    model_clear();
    @(posedge hclk); #1;
  endtask

  initial begin
    cur = 1'b0;
    ws  = 0;
    do_reset();

    @(negedge hclk);
    check("rst_ready",   W'(cur_ready), W'(1));
    check("rst_resp",    W'(cur_resp),  W'(0));
    check("rst_rdata",   W'(cur_rdata), W'(0));
    check("rst_state",   W'(cur_st),    W'(ST_IDLE));
    check_regs("rst");
    @(posedge hclk); #1;

    add(HTRANS_NONSEQ, 1'b1, 3'd2, 3'd2, 32'hDEADBEEF);
    run_queue("wr_payload");
    check("payload_deadbeef", W'(cur_pay), W'(32'hDEADBEEF));

    add(HTRANS_NONSEQ, 1'b1, 3'd1, 3'd0, 32'h0000_00FF);
    run_queue("wr_status");
    check("err_count_one", W'(cur_err), W'(16'd1));
    check_regs("after_err");

    add(HTRANS_NONSEQ, 1'b1, 3'd3, 3'd0, 32'h0000_00A5);
    add(HTRANS_SEQ,    1'b0, 3'd3, 3'd0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, 3'd1, 3'd1, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, 3'd3, 3'd2, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, 3'd2, 3'd1, 32'h1234_5678);
    add(HTRANS_NONSEQ, 1'b0, 3'd2, 3'd2, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, 3'd6, 3'd0, 32'h0);
    run_queue("b2b");
    check_regs("b2b");

    add_random(40);
    run_queue("rnd0");
    check_regs("rnd0");

    cur = 1'b1;
    ws  = 2;
    do_reset();
    add(HTRANS_NONSEQ, 1'b1, 3'd4, 3'd1, 32'hFFFF_0040);
    add(HTRANS_NONSEQ, 1'b0, 3'd4, 3'd1, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, 3'd3, 3'd0, 32'h0000_00A5);
    add(HTRANS_SEQ,    1'b0, 3'd3, 3'd0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, 3'd0, 3'd0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, 3'd1, 3'd0, 32'h0);
    run_queue("ws2");
    check("dsize_0040", W'(cur_ds), W'(16'h0040));

    add_random(40);
    run_queue("rnd2");
    check_regs("rnd2");

    // Reset while the slave is in ERR1.
    m_hsel = 1'b1; m_htrans = HTRANS_NONSEQ; m_hwrite = 1'b1;
    m_haddr = 3'd1; m_hsize = 3'd0; m_hwdata = 32'h0;
    @(negedge hclk);
    check("err_addr_ready", W'(cur_ready), W'(1));
    @(posedge hclk); #1;
    bus_idle();
    @(negedge hclk);
    check("err1_ready", W'(cur_ready), W'(0));
    check("err1_resp",  W'(cur_resp),  W'(1));
    check("err1_count", W'(cur_err),   W'(m_err + 16'd1));
    #2 hresetn = 1'b0;
    #1;
    check("mid_rst_ready", W'(cur_ready), W'(1));
    check("mid_rst_resp",  W'(cur_resp),  W'(0));
    check("mid_rst_count", W'(cur_err),   W'(0));
    check("mid_rst_state", W'(cur_st),    W'(ST_IDLE));
    @(negedge hclk);
    hresetn = 1'b1;
    model_clear();
    @(posedge hclk); #1;
    m_hsel = 1'b1; m_htrans = HTRANS_BUSY; m_hwrite = 1'b1;
    m_haddr = 3'd2; m_hsize = 3'd2; m_hwdata = 32'h1234_5678;
    @(negedge hclk);
    check("busy_ready", W'(cur_ready), W'(1));
    check("busy_resp",  W'(cur_resp),  W'(0));
    @(posedge hclk); #1;
    m_hsel = 1'b0; m_htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("busy_after_ready", W'(cur_ready), W'(1));
    check("busy_after_resp",  W'(cur_resp),  W'(0));
    check("busy_after_rdata", W'(cur_rdata), W'(0));
    check("busy_after_state", W'(cur_st),    W'(ST_IDLE));
    check_regs("busy");
    @(posedge hclk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_reg_slave_ctrl.md
AHB_REG_SLAVE_CTRL -- requirements
Module: ahb_reg_slave_ctrl

Interface
REQ-001 SHALL have parameter ERR_STATUS_ADDRESS, default 1, read-only error-status register address.
REQ-002 SHALL have parameter PAYLOAD_ADDRESS, default 2, payload register address; PAYLOAD_ADDRESS+1 is the payload-extension register address.
REQ-003 SHALL have parameter DATA_SIZE_ADDRESS, default 4, data-size register address.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..3, wait cycles inserted on OKAY transfers.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-006 hclk  in  1  clock, all state on rising edge.
REQ-007 hresetn  in  1  asynchronous active-low reset.
REQ-008 hsel_x, hwrite, hreadyin  in  1 each  slave select, write direction, bus ready.
REQ-009 haddr  in  3  address; htrans  in  2  transfer type; hsize  in  3  transfer size.
REQ-010 hwdata  in  32  write data (data phase); hrdata  out  32  read data.
REQ-011 hreadyout  out  1  transfer done; hresp  out  1  0=OKAY, 1=ERROR.
REQ-012 payload_q  out  32; payload_ext_q  out  16; data_size_q  out  16; err_count  out  16.

Function
REQ-013 SHALL accept an address phase when hsel_x=1, hreadyin=1 and htrans[1]=1 (NONSEQ/SEQ), capturing haddr, hwrite, hsize and the decode result.
REQ-014 Decode: a write to ERR_STATUS_ADDRESS is an error. Otherwise, a transfer is an error if the address is unmapped, or if hsize exceeds the limit for its register: 1 for ERR_STATUS, PAYLOAD+1 and DATA_SIZE; 2 for PAYLOAD.
REQ-015 IDLE/BUSY with hsel_x=1 SHALL get a zero-wait OKAY response and cause no capture and no register change.
REQ-016 FSM states are IDLE, WAIT, ERR1 and ERR2.
REQ-017 IDLE: hreadyout=1, hresp=0. On an accepted OKAY transfer, go to WAIT if WAIT_STATES>0, else complete next cycle in IDLE. On an accepted error transfer, go to ERR1.
REQ-018 WAIT: hreadyout=0, hresp=0 for exactly WAIT_STATES cycles using a 2-bit down-counter, then one completing cycle with hreadyout=1.
REQ-019 ERR1: hreadyout=0, hresp=1, 1 cycle, then go to ERR2. ERR2: hreadyout=1, hresp=1, 1 cycle, then go to IDLE.
REQ-020 A new address phase SHALL be accepted on any completing cycle (hreadyout=1, including ERR2); none is accepted while hreadyout=0.
REQ-021 OKAY write: update the target register from hwdata at the completing data-phase cycle. hsize 0 writes bits [7:0], 1 writes [15:0], 2 writes [31:0]; bits not written are retained; bits beyond the register width are ignored.
REQ-022 OKAY read: hrdata = zero-extended selected register during the data phase; hrdata = 0 otherwise and for errored transfers.
REQ-023 ERR_STATUS read SHALL return {16'h0, err_count}.
REQ-024 err_count SHALL increment by 1 on each ERR1 entry and saturate at 16'hFFFF.
REQ-025 Errored transfers SHALL never modify any register.

Reset
REQ-026 On hresetn=0, at any time including mid-transfer: state=IDLE, wait counter=0, hreadyout=1, hresp=0, hrdata=0, all registers and err_count=0; the pending transfer is discarded.

Structure
REQ-027 Package ahb_slave_pkg SHALL hold the FSM state enum, the htrans encodings (IDLE/BUSY/NONSEQ/SEQ), the hsize encodings and the default register address constants.
REQ-028 Decode SHALL be a single combinational sub-module instance, AHB_address_mapping. Sequencing, registers and the counter live in ahb_reg_slave_ctrl.

Verification
REQ-029 WAIT_STATES=0, NONSEQ write haddr=2, hsize=2, hwdata=32'hDEADBEEF -> hreadyout=1, hresp=0; payload_q=32'hDEADBEEF the following cycle.
REQ-030 Write haddr=1 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); err_count=1; no register changes.
REQ-031 WAIT_STATES=2, read haddr=4 after data_size_q=16'h0040 -> 2 cycles hreadyout=0, then hrdata=32'h40 with hreadyout=1.
REQ-032 Back-to-back: write haddr=3, hsize=0, hwdata=8'hA5, pipelined with read haddr=3 -> the read returns 32'hA5 with no bubble.
REQ-033 hresetn asserted during ERR1 -> next cycle hreadyout=1, hresp=0, err_count=0; htrans=BUSY with hsel_x=1 -> zero-wait OKAY.
